// File: rtl/bus_cycle_controller.sv
// Sequences the 8-phase A1..X3 bus cycle and emits sync, advance and CM-ROM/CM-RAM strobes, with debug halt/step.
// Latency: one IDLE clock after reset, then one phase per clock; halt_req is honoured only at the X3->A1 boundary.
module bus_cycle_controller #(
    parameter int unsigned NUM_RAM_BANKS = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     halt_req,
    input  logic                     step,
    input  logic                     io_exec,
    input  logic                     src_exec,
    input  logic                     dcl_write,
    input  logic [2:0]               dcl_value,
    output logic [2:0]               phase,
    output logic                     sync,
    output logic                     advance,
    output logic                     cycle_done,
    output logic                     halted,
    output logic                     cm_rom,
    output logic [NUM_RAM_BANKS-1:0] cm_ram,
    output logic [1:0]               bank_sel
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2,
        STEP   = 2'd3
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [2:0] phase_nxt;
    logic [1:0] bank_nxt;
    logic [1:0] dcl_bank;
    logic       strobe;

    // Only the low two accumulator bits select a bank; fold them onto the populated banks.
    assign dcl_bank = 2'(32'(dcl_value[1:0]) % NUM_RAM_BANKS);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            phase    <= 3'd0;
            bank_sel <= 2'd0;
        end else begin
            state    <= state_nxt;
            phase    <= phase_nxt;
            bank_sel <= bank_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        phase_nxt = phase;
        bank_nxt  = bank_sel;
        unique case (state)
            IDLE: begin
                state_nxt = RUN;
                phase_nxt = 3'd0;
            end
            RUN, STEP: begin
                phase_nxt = phase + 3'd1;
                if (phase == 3'd7) begin
                    // A step is exactly one cycle: both RUN and STEP re-evaluate halt here.
                    state_nxt = halt_req ? HALTED : RUN;
                    if (dcl_write) begin
                        bank_nxt = dcl_bank;
                    end
                end
            end
            HALTED: begin
                phase_nxt = 3'd0;
                if (!halt_req) begin
                    state_nxt = RUN;
                end else if (step) begin
                    state_nxt = STEP;
                end
            end
            default: begin
                state_nxt = IDLE;
                phase_nxt = 3'd0;
            end
        endcase
    end

    always_comb begin
        advance    = (state == RUN) || (state == STEP);
        halted     = (state == HALTED);
        sync       = advance && (phase == 3'd7);
        cycle_done = sync;
        strobe     = advance && ((phase == 3'd2) ||
                                 ((phase == 3'd4) && io_exec) ||
                                 ((phase == 3'd6) && src_exec));
        cm_rom     = strobe;
        cm_ram     = '0;
        for (int i = 0; i < int'(NUM_RAM_BANKS); i++) begin
            cm_ram[i] = strobe && (bank_sel == 2'(i));
        end
    end

endmodule

// File: tb/tb_bus_cycle_controller.sv
// Scoreboard bench: the driver predicts each cycle's outputs into a queue, the monitor pops and compares.
module tb_bus_cycle_controller;

    logic       clock;
    logic       reset;
    logic       halt_req;
    logic       step;
    logic       io_exec;
    logic       src_exec;
    logic       dcl_write;
    logic [2:0] dcl_value;

    logic [2:0] phase, phase2;
    logic       sync, advance, cycle_done, halted, cm_rom;
    logic       sync2, advance2, cycle_done2, halted2, cm_rom2;
    logic [3:0] cm_ram;
    logic [1:0] cm_ram2;
    logic [1:0] bank_sel, bank_sel2;

    bus_cycle_controller #(.NUM_RAM_BANKS(4)) u_dut (
        .clock(clock), .reset(reset), .halt_req(halt_req), .step(step),
        .io_exec(io_exec), .src_exec(src_exec), .dcl_write(dcl_write), .dcl_value(dcl_value),
        .phase(phase), .sync(sync), .advance(advance), .cycle_done(cycle_done),
        .halted(halted), .cm_rom(cm_rom), .cm_ram(cm_ram), .bank_sel(bank_sel)
    );

    bus_cycle_controller #(.NUM_RAM_BANKS(2)) u_dut2 (
        .clock(clock), .reset(reset), .halt_req(halt_req), .step(step),
        .io_exec(io_exec), .src_exec(src_exec), .dcl_write(dcl_write), .dcl_value(dcl_value),
        .phase(phase2), .sync(sync2), .advance(advance2), .cycle_done(cycle_done2),
        .halted(halted2), .cm_rom(cm_rom2), .cm_ram(cm_ram2), .bank_sel(bank_sel2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;
    int adv_cnt  = 0;
    int sync_cnt = 0;

    logic [18:0] exp_q[$];

    // Model state: 0 IDLE, 1 RUN, 2 HALTED, 3 STEP
    int         m_state = 0;
    logic [2:0] m_phase = 3'd0;
    logic [1:0] m_bank  = 2'd0;
    logic [1:0] m_bank2 = 2'd0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic [18:0] observed();
        return {phase, sync, advance, cycle_done, halted, cm_rom, cm_ram, bank_sel, cm_ram2, bank_sel2};
    endfunction

    function automatic logic [18:0] predict(input logic io, input logic src);
        logic       adv, stb, syn;
        logic [3:0] ram;
        logic [1:0] ram2;
        adv  = (m_state == 1) || (m_state == 3);
        syn  = adv && (m_phase == 3'd7);
        stb  = adv && (m_phase == 3'd2 || (m_phase == 3'd4 && io) || (m_phase == 3'd6 && src));
        ram  = 4'd0;
        ram2 = 2'd0;
        if (stb) begin
            ram[m_bank]   = 1'b1;
            ram2[m_bank2] = 1'b1;
        end
        return {m_phase, syn, adv, syn, (m_state == 2), stb, ram, m_bank, ram2, m_bank2};
    endfunction

    always @(negedge clock) begin
        logic [18:0] e;
        #2;
        if (advance) adv_cnt++;
        if (sync) sync_cnt++;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check_eq($sformatf("outputs_ph%0d", e[18:16]), 32'(observed()), 32'(e));
        end
    end

    task automatic cyc(input logic rst, input logic h, input logic st, input logic io,
                       input logic src, input logic dw, input logic [2:0] dv);
        @(negedge clock);
        #1;
        reset = rst; halt_req = h; step = st; io_exec = io; src_exec = src;
        dcl_write = dw; dcl_value = dv;
        exp_q.push_back(predict(io, src));
        if (!rst) begin
            m_state = 0; m_phase = 3'd0; m_bank = 2'd0; m_bank2 = 2'd0;
        end else begin
            case (m_state)
                0: begin m_state = 1; m_phase = 3'd0; end
                1, 3: begin
                    if (m_phase == 3'd7) begin
                        m_state = h ? 2 : 1;
                        if (dw) begin
                            m_bank  = dv[1:0];
                            m_bank2 = {1'b0, dv[0]};
                        end
                    end
                    m_phase = m_phase + 3'd1;
                end
                default: begin
                    if (!h) m_state = 1;
                    else if (st) m_state = 3;
                    m_phase = 3'd0;
                end
            endcase
        end
    endtask

    task automatic run_to(input logic [2:0] p, input logic h, input logic io, input logic src);
        int guard = 0;
        while (m_phase != p && guard < 16) begin
            cyc(1'b1, h, 1'b0, io, src, 1'b0, 3'd0);
            guard++;
        end
        if (guard >= 16) check_eq("run_to_timeout", 32'(m_phase), 32'(p));
    endtask

    initial begin
        int a0, s0, guard;
        reset = 1'b0; halt_req = 1'b0; step = 1'b0; io_exec = 1'b0;
        src_exec = 1'b0; dcl_write = 1'b0; dcl_value = 3'd0;

        // Reset, then free-running cycles
        cyc(1'b0, 0, 0, 0, 0, 0, 3'd0);
        cyc(1'b0, 0, 0, 0, 0, 0, 3'd0);
        cyc(1'b1, 0, 0, 0, 0, 0, 3'd0);
        for (int i = 0; i < 18; i++) cyc(1'b1, 0, 0, 0, 0, 0, 3'd0);

        // Halt request at phase 3 finishes the cycle, then stays halted
        run_to(3'd3, 1'b0, 1'b0, 1'b0);
        guard = 0;
        while (m_state != 2 && guard < 16) begin
            cyc(1'b1, 1, 0, 0, 0, 0, 3'd0);
            guard++;
        end
        check_eq("halt_reached", 32'(m_state), 32'd2);
        #2;
        s0 = sync_cnt;
        for (int i = 0; i < 20; i++) cyc(1'b1, 1, 0, 0, 0, 0, 3'd0);
        #2;
        check_eq("halted_sync_count", 32'(sync_cnt - s0), 32'd0);

        // Single step, with a second step pulse mid-step that must be ignored
        a0 = adv_cnt; s0 = sync_cnt;
        cyc(1'b1, 1, 1, 0, 0, 0, 3'd0);
        for (int i = 0; i < 11; i++) cyc(1'b1, 1, (i == 3), 0, 0, 0, 3'd0);
        #2;
        check_eq("step_advance_count", 32'(adv_cnt - a0), 32'd8);
        check_eq("step_sync_count", 32'(sync_cnt - s0), 32'd1);
        check_eq("step_rehalted", 32'(halted), 32'd1);

        // Resume, DCL select bank 2, then I/O instruction cycle
        cyc(1'b1, 0, 0, 0, 0, 0, 3'd0);
        run_to(3'd7, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 0, 0, 0, 0, 1, 3'b010);
        for (int i = 0; i < 8; i++) cyc(1'b1, 0, 0, 1, 0, 0, 3'd0);

        // DCL outside phase 7 is ignored; then SRC cycle
        run_to(3'd5, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 0, 0, 0, 0, 1, 3'd3);
        run_to(3'd0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) cyc(1'b1, 0, 0, 0, 1, 0, 3'd0);

        // dcl_value[2] ignored; bank 3 on 4 banks, bank 1 on 2 banks
        run_to(3'd7, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 0, 0, 0, 0, 1, 3'b111);
        for (int i = 0; i < 8; i++) cyc(1'b1, 0, 0, (i < 4), (i >= 4), 0, 3'd0);
        check_eq("bank_sel_dcl3", 32'(m_bank), 32'd3);

        // Halt, step, then asynchronous reset at phase 5 of the step
        run_to(3'd7, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1, 0, 0, 0, 0, 3'd0);
        cyc(1'b1, 1, 1, 0, 0, 0, 3'd0);
        run_to(3'd5, 1'b1, 1'b0, 1'b0);
        @(negedge clock);
        #3;
        reset = 1'b0;
        #1;
        check_eq("async_reset_outputs", 32'(observed()), 32'd0);
        m_state = 0; m_phase = 3'd0; m_bank = 2'd0; m_bank2 = 2'd0;
        cyc(1'b0, 0, 0, 0, 0, 0, 3'd0);
        cyc(1'b1, 0, 0, 0, 0, 0, 3'd0);
        for (int i = 0; i < 10; i++) cyc(1'b1, 0, 0, (i == 4), 0, 0, 3'd0);

        @(negedge clock);
        #3;
        check_eq("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
